enter_pulse_gen: RTL and testbench

//  Conditions the raw ENTER push-button for the peripherals unit: synchronises it, debounces

---
 rtl/enter_pulse_gen.sv | 135 +++++++++++++
 tb/tb_enter_pulse_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enter_pulse_gen.sv
// ENTER push-button conditioner: synchronise, debounce press and release, and emit one
// registered strobe per accepted press, plus optional auto-repeat strobes while held.
module enter_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic pulse,
    output logic level
);

    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Normalise polarity before the chain so reset can load a plain 0 (released).
    logic                   btn_raw;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       rep_last;

    assign btn_raw = (BTN_ACTIVE_LOW != 0) ? ~enter : enter;
    assign btn_s   = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        pulse_d  = 1'b0;
        rep_last = first_q ? DELAY_LAST : PERIOD_LAST;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // A release seen this cycle wins over a repeat that would fall due.
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_q == rep_last) begin
                        cnt_d   = '0;
                        first_d = 1'b0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Very short repeat settings must still never yield back-to-back strobes.
        pulse_d = pulse_d & ~pulse_q;
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b1;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: tb/tb_enter_pulse_gen.sv
// Directed bench for enter_pulse_gen: three instances cover active-low/no-repeat,
// active-low/auto-repeat and active-high inputs with a small debounce setting.
module tb_enter_pulse_gen;

    logic clk;
    logic reset;
    logic enter_a, enter_b, enter_c;
    logic pulse_a, pulse_b, pulse_c;
    logic level_a, level_b, level_c;

    int checks   = 0;
    int failures = 0;

    enter_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(1),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut_a (
        .clk(clk), .reset(reset), .enter(enter_a), .pulse(pulse_a), .level(level_a)
    );

    enter_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(1),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut_b (
        .clk(clk), .reset(reset), .enter(enter_b), .pulse(pulse_b), .level(level_b)
    );

    enter_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(0),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut_c (
        .clk(clk), .reset(reset), .enter(enter_c), .pulse(pulse_c), .level(level_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // driver: advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        enter_a = 1'b1;
        enter_b = 1'b1;
        enter_c = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (pulse_a !== 1'b0) begin failures++; $display("FAIL reset pulse_a got=%b exp=0", pulse_a); end
        if (level_a !== 1'b0) begin failures++; $display("FAIL reset level_a got=%b exp=0", level_a); end
        if (pulse_b !== 1'b0) begin failures++; $display("FAIL reset pulse_b got=%b exp=0", pulse_b); end
        if (level_b !== 1'b0) begin failures++; $display("FAIL reset level_b got=%b exp=0", level_b); end
        if (pulse_c !== 1'b0) begin failures++; $display("FAIL reset pulse_c got=%b exp=0", pulse_c); end
        if (level_c !== 1'b0) begin failures++; $display("FAIL reset level_c got=%b exp=0", level_c); end
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks += 2;
            if (pulse_a !== 1'b0) begin failures++; $display("FAIL reset_release pulse k=%0d got=%b exp=0", k, pulse_a); end
            if (level_a !== 1'b0) begin failures++; $display("FAIL reset_release level k=%0d got=%b exp=0", k, level_a); end
        end
    endtask

    // press at E0 (k=0), release after k=20; pulse at k=7, level over [7,27)
    task automatic test_clean_press();
        logic exp_p, exp_l;
        tick();
        enter_a = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_p = (k == 7);
            exp_l = (k >= 7) && (k < 27);
            checks += 2;
            if (pulse_a !== exp_p) begin failures++; $display("FAIL clean_press pulse k=%0d got=%b exp=%b", k, pulse_a, exp_p); end
            if (level_a !== exp_l) begin failures++; $display("FAIL clean_press level k=%0d got=%b exp=%b", k, level_a, exp_l); end
            if (k == 20) enter_a = 1'b1;
        end
    endtask

    // toggles at k=2..12 every 2 cycles, stable press from k=12, release at k=22
    task automatic test_bounce();
        logic exp_p, exp_l;
        tick();
        enter_a = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_p = (k == 19);
            exp_l = (k >= 19) && (k < 29);
            checks += 2;
            if (pulse_a !== exp_p) begin failures++; $display("FAIL bounce pulse k=%0d got=%b exp=%b", k, pulse_a, exp_p); end
            if (level_a !== exp_l) begin failures++; $display("FAIL bounce level k=%0d got=%b exp=%b", k, level_a, exp_l); end
            if (k >= 2 && k <= 12 && (k % 2) == 0) enter_a = ~enter_a;
            if (k == 22) enter_a = 1'b1;
        end
    endtask

    // released for 2 cycles at k=12..14 while PRESSED, final release at k=24
    task automatic test_release_glitch();
        logic exp_p, exp_l;
        tick();
        enter_a = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_p = (k == 7);
            exp_l = (k >= 7) && (k < 31);
            checks += 2;
            if (pulse_a !== exp_p) begin failures++; $display("FAIL release_glitch pulse k=%0d got=%b exp=%b", k, pulse_a, exp_p); end
            if (level_a !== exp_l) begin failures++; $display("FAIL release_glitch level k=%0d got=%b exp=%b", k, level_a, exp_l); end
            if (k == 12) enter_a = 1'b1;
            if (k == 14) enter_a = 1'b0;
            if (k == 24) enter_a = 1'b1;
        end
    endtask

    // PRESSED starts at k=7: pulses at +0,+10,+15,+20,+25,+30; release at k=38
    task automatic test_auto_repeat();
        logic exp_p, exp_l;
        int   npulse;
        npulse = 0;
        tick();
        enter_b = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            exp_p = (k == 7) || (k == 17) || (k == 22) || (k == 27) || (k == 32) || (k == 37);
            exp_l = (k >= 7) && (k < 45);
            if (pulse_b === 1'b1) npulse++;
            checks += 2;
            if (pulse_b !== exp_p) begin failures++; $display("FAIL auto_repeat pulse k=%0d got=%b exp=%b", k, pulse_b, exp_p); end
            if (level_b !== exp_l) begin failures++; $display("FAIL auto_repeat level k=%0d got=%b exp=%b", k, level_b, exp_l); end
            if (k == 38) enter_b = 1'b1;
        end
        checks++;
        if (npulse != 6) begin failures++; $display("FAIL auto_repeat count got=%0d exp=6", npulse); end
    endtask

    // reset asserted at k=6 (PRESS_WAIT, counter=3), released at k=8 with key held
    task automatic test_reset_mid_press();
        logic exp_p, exp_l;
        tick();
        enter_a = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_p = (k == 15);
            exp_l = (k >= 15) && (k < 27);
            checks += 2;
            if (pulse_a !== exp_p) begin failures++; $display("FAIL reset_mid pulse k=%0d got=%b exp=%b", k, pulse_a, exp_p); end
            if (level_a !== exp_l) begin failures++; $display("FAIL reset_mid level k=%0d got=%b exp=%b", k, level_a, exp_l); end
            if (k == 6) begin
                reset = 1'b0;
                #1;
                checks += 2;
                if (pulse_a !== 1'b0) begin failures++; $display("FAIL reset_mid_async pulse got=%b exp=0", pulse_a); end
                if (level_a !== 1'b0) begin failures++; $display("FAIL reset_mid_async level got=%b exp=0", level_a); end
            end
            if (k == 8) reset = 1'b1;
            if (k == 20) enter_a = 1'b1;
        end
    endtask

    // same timing as the clean press, active-high input
    task automatic test_active_high();
        logic exp_p, exp_l;
        tick();
        enter_c = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_p = (k == 7);
            exp_l = (k >= 7) && (k < 27);
            checks += 2;
            if (pulse_c !== exp_p) begin failures++; $display("FAIL active_high pulse k=%0d got=%b exp=%b", k, pulse_c, exp_p); end
            if (level_c !== exp_l) begin failures++; $display("FAIL active_high level k=%0d got=%b exp=%b", k, level_c, exp_l); end
            if (k == 20) enter_c = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_auto_repeat();
        test_reset_mid_press();
        test_active_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
